// File: rtl/mux_sel_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin mux-select arbiter.
package mux_sel_arbiter_pkg;

  localparam int N_CH   = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Pointer value after reset: the first search then starts at channel 0.
  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

  // Channel index to one-hot grant vector.
  function automatic logic [N_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from (last+1) with wrap-around. The channel at 'last' has lowest priority.
module mux_sel_arbiter_rr_pick
  import mux_sel_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // rot[k] is the request of channel (last + 1 + k) mod N_CH
  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
    localparam logic [SEL_W-1:0] OFS = SEL_W'(gi + 1);
    assign rot[gi] = req[last + OFS];
  end

  // Lowest set bit of the rotated vector is the nearest requester after 'last'.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  // Undo the rotation; 3-bit arithmetic wraps modulo N_CH.
  assign idx = last + off + SEL_W'(1);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 channel mux, capturing the
// mux word one cycle after the select settles and presenting it on valid/ready.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic [DATA_W-1:0] mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic [N_CH-1:0]   grant,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [SEL_W-1:0]  last_q, last_d;

  logic [SEL_W-1:0]  pick_ptr;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  // In HOLD the only search that matters is the one at the handshake, where the
  // channel being served (sel) becomes the new lowest-priority pointer.
  always_comb begin
    pick_ptr = (state_q == ST_HOLD) ? sel_q : last_q;
  end

  mux_sel_arbiter_rr_pick u_pick (
    .req   (req),
    .last  (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-output logic for the IDLE/SELECT/HOLD sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          grant_d = idx_to_onehot(pick_idx);
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        // Mux has had a full cycle to settle on the registered select.
        data_d  = mux_out;
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (ready_in) begin
          last_d  = sel_q;
          valid_d = 1'b0;
          if (pick_found) begin
            sel_d   = pick_idx;
            grant_d = idx_to_onehot(pick_idx);
            state_d = ST_SELECT;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        grant_d = '0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= PTR_RST;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] mux_out;
  logic [2:0] sel;
  logic [7:0] grant;
  logic [2:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       busy;

  logic [2:0] chan_word [8];

  int n_checks = 0;
  int n_fail   = 0;

  mux_sel_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mux_out   (mux_out),
    .sel       (sel),
    .grant     (grant),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .busy      (busy)
  );

  // The 8:1 mux the arbiter drives: each channel presents its current word.
  assign mux_out = chan_word[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the channel, whether its word is still being fetched,
  // the word on offer, and the round-robin pointer.
  int m_owner;   // -1 when no channel holds a grant
  int m_sel;
  int m_last;
  int m_data;
  bit m_valid;
  bit m_fetch;   // granted, word not yet captured
  int n_txn;

  function automatic int rr_search(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (last + k) % 8;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    n_txn = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_sel = 0; m_last = 7; m_data = 0; m_valid = 0; m_fetch = 0;
      end else begin
        int w;
        if (m_owner < 0) begin
          w = rr_search(req, m_last);
          if (w >= 0) begin
            m_owner = w; m_sel = w; m_fetch = 1;
          end
        end else if (m_fetch) begin
          m_data  = int'(chan_word[m_sel]);
          m_valid = 1;
          m_fetch = 0;
        end else if (ready_in) begin
          n_txn++;
          $display("txn %0d: ch=%0d data=%0d", n_txn, m_sel, m_data);
          m_last  = m_sel;
          m_valid = 0;
          w = rr_search(req, m_last);
          if (w >= 0) begin
            m_owner = w; m_sel = w; m_fetch = 1;
          end else begin
            m_owner = -1;
          end
        end
      end
    end
  end

  // Every cycle out of reset, the DUT outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("model_sel",   32'(sel),       32'(m_sel));
        chk("model_grant", 32'(grant),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_valid", 32'(valid_out), 32'(m_valid));
        chk("model_data",  32'(data_out),  32'(m_data));
        chk("model_busy",  32'(busy),      (m_owner >= 0) ? 32'd1 : 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    req      = '0;
    ready_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the next cycle whose upcoming edge is a handshake.
  task automatic next_hs(output int ch, output int waited);
    ch     = -1;
    waited = 0;
    while (ch < 0 && waited < 20) begin
      @(negedge clk);
      waited++;
      if (valid_out && ready_in) ch = int'(sel);
    end
  endtask

  int exp81 [3] = '{0, 7, 0};

  initial begin
    int ch, waited;
    rst_n    = 1'b0;
    req      = '0;
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) chan_word[i] = 3'd0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_sel",   32'(sel),       0);
    chk("rst_grant", 32'(grant),     0);
    chk("rst_data",  32'(data_out),  0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_busy",  32'(busy),      0);
    rst_n = 1'b1;

    // Single request on channel 2, word 5; request dropped in SELECT;
    // consumer stalls for 5 cycles.
    chan_word[2] = 3'd5;
    req          = 8'h04;
    @(negedge clk);
    chk("t1_sel",       32'(sel),   2);
    chk("t1_grant",     32'(grant), 32'h04);
    chk("t1_busy",      32'(busy),  1);
    chk("t1_valid_lo",  32'(valid_out), 0);
    chk("t1_model_sel", 32'(m_sel), 2);
    req = 8'h00;
    @(negedge clk);
    chk("t1_valid",      32'(valid_out), 1);
    chk("t1_data",       32'(data_out),  5);
    chk("t1_model_data", 32'(m_data),    5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_hold_data",  32'(data_out),  5);
      chk("t1_hold_sel",   32'(sel),       2);
      chk("t1_hold_grant", 32'(grant),     32'h04);
      chk("t1_hold_valid", 32'(valid_out), 1);
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("t1_post_valid", 32'(valid_out), 0);
    chk("t1_post_grant", 32'(grant),     0);
    chk("t1_post_busy",  32'(busy),      0);
    ready_in = 1'b0;

    // Wrap-around fairness with channels 0 and 7
    do_reset();
    req      = 8'h81;
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_hs(ch, waited);
      chk("rr81_ch", 32'(ch), 32'(exp81[k]));
    end
    req = 8'h00;
    repeat (4) @(negedge clk);

    // All channels requesting: 0..7,0 one word per 2 cycles
    do_reset();
    req      = 8'hFF;
    ready_in = 1'b1;
    for (int k = 0; k < 9; k++) begin
      next_hs(ch, waited);
      chk("ff_ch", 32'(ch), 32'(k % 8));
      if (k > 0) chk("ff_spacing", 32'(waited), 2);
    end
    req = 8'h00;
    repeat (4) @(negedge clk);

    // Reset asserted while HOLD presents a word
    chan_word[6] = 3'd3;
    req          = 8'h40;
    ready_in     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rsth_valid_before", 32'(valid_out), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rsth_sel",   32'(sel),       0);
    chk("rsth_grant", 32'(grant),     0);
    chk("rsth_data",  32'(data_out),  0);
    chk("rsth_valid", 32'(valid_out), 0);
    chk("rsth_busy",  32'(busy),      0);
    req = 8'h30;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rsth_first_sel",   32'(sel),   4);
    chk("rsth_first_grant", 32'(grant), 32'h10);
    ready_in = 1'b1;
    repeat (6) @(negedge clk);
    req = 8'h00;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) req = 8'hFF;
      ready_in = ($urandom_range(0, 3) != 0);
      chan_word[$urandom_range(0, 7)] = 3'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    req      = 8'h00;
    ready_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("end_idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
